// File: rtl/win_r_pkg.sv
// Shared widths and arithmetic helpers for the multi-channel range-window stage.
package win_r_pkg;

    localparam int NUM_CH_DEF = 2;
    localparam int DATA_W_DEF = 16;
    localparam int COEF_W_DEF = 16;
    localparam int OUT_W_DEF  = 16;
    localparam int ADDR_W_DEF = 13;

    localparam int IDX_W   = 16;  // sample index and chirp length width
    localparam int SHIFT_W = 5;   // cfg_shift width
    localparam int WIDE_W  = 64;  // headroom for rounding arithmetic

    // Signed product width and the largest shift that still leaves OUT_W bits
    localparam int PROD_W    = DATA_W_DEF + COEF_W_DEF + 1;
    localparam int SHIFT_MAX = PROD_W - OUT_W_DEF;

    // Mirror the second half of the window onto the first half of the table
    function automatic logic [IDX_W-1:0] sym_offset(input logic [IDX_W-1:0] idx,
                                                    input logic [IDX_W-1:0] len);
        logic [IDX_W:0] half;
        half = ({1'b0, len} + (IDX_W+1)'(1)) >> 1;
        if ({1'b0, idx} < half) return idx;
        return len - idx - IDX_W'(1);
    endfunction

    // Clamp the requested shift to the largest useful value
    function automatic int eff_shift(input logic [SHIFT_W-1:0] shift, input int max_s);
        int s;
        s = int'(shift);
        return (s > max_s) ? max_s : s;
    endfunction

    // Round half up, then arithmetic right shift
    function automatic logic signed [WIDE_W-1:0] round_shift(input logic signed [WIDE_W-1:0] p,
                                                             input int s);
        logic signed [WIDE_W-1:0] r;
        r = p;
        if (s > 0) r = p + (WIDE_W'(1) <<< (s - 1));
        return r >>> s;
    endfunction

    // True when a value does not fit in an out_w-bit signed field
    function automatic logic out_of_range(input logic signed [WIDE_W-1:0] v, input int out_w);
        logic signed [WIDE_W-1:0] hi;
        logic signed [WIDE_W-1:0] lo;
        hi = (WIDE_W'(1) <<< (out_w - 1)) - WIDE_W'(1);
        lo = -(WIDE_W'(1) <<< (out_w - 1));
        return (v > hi) || (v < lo);
    endfunction

    // Clamp to the out_w-bit signed range
    function automatic logic signed [WIDE_W-1:0] saturate(input logic signed [WIDE_W-1:0] v,
                                                          input int out_w);
        logic signed [WIDE_W-1:0] hi;
        logic signed [WIDE_W-1:0] lo;
        hi = (WIDE_W'(1) <<< (out_w - 1)) - WIDE_W'(1);
        lo = -(WIDE_W'(1) <<< (out_w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/win_r_scale.sv
// One I or Q component: registered multiply, then round/shift/saturate (3 stages).
module win_r_scale
    import win_r_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int COEF_W = COEF_W_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   data_i,
    input  logic [COEF_W-1:0]   coef_i,
    input  logic [SHIFT_W-1:0]  shift_i,
    output logic [OUT_W-1:0]    res_o,
    output logic                sat_o
);

    localparam int MUL_W = DATA_W + COEF_W + 1;

    logic signed [DATA_W-1:0] a_q;
    logic        [COEF_W-1:0] b_q;
    logic       [SHIFT_W-1:0] sh_a_q;
    logic signed  [MUL_W-1:0] prod_d, prod_q;
    logic       [SHIFT_W-1:0] sh_p_q;
    logic signed [WIDE_W-1:0] rnd;
    logic         [OUT_W-1:0] res_d, res_q;
    logic                     sat_d, sat_q;

    // Signed sample times zero-extended coefficient, then scale the registered product
    always_comb begin
        prod_d = MUL_W'(a_q) * MUL_W'($signed({1'b0, b_q}));
        rnd    = round_shift(WIDE_W'(prod_q), eff_shift(sh_p_q, MUL_W - OUT_W));
        sat_d  = out_of_range(rnd, OUT_W);
        res_d  = OUT_W'(saturate(rnd, OUT_W));
    end

    // Multiplier input, product and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            sh_a_q <= '0;
            prod_q <= '0;
            sh_p_q <= '0;
            res_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            // NOTE: state is updated with <= so every stage samples the previous stage's old value
            a_q    <= data_i;
            b_q    <= coef_i;
            sh_a_q <= shift_i;
            prod_q <= prod_d;
            sh_p_q <= sh_a_q;
            res_q  <= res_d;
            sat_q  <= sat_d;
        end
    end

    assign res_o = res_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/win_r_mc.sv
// Multi-channel range window: index/address generation, coefficient RAM,
// per-component scale lanes, sticky flags. Fixed 6-cycle latency.
module win_r_mc
    import win_r_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int COEF_W = COEF_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_valid,
    input  logic [NUM_CH*2*DATA_W-1:0] s_data,
    input  logic                       s_sop,
    input  logic                       s_eop,
    input  logic [IDX_W-1:0]           cfg_len,
    input  logic [ADDR_W-1:0]          cfg_base,
    input  logic                       cfg_sym,
    input  logic [SHIFT_W-1:0]         cfg_shift,
    input  logic                       coef_we,
    input  logic [ADDR_W-1:0]          coef_waddr,
    input  logic [COEF_W-1:0]          coef_wdata,
    input  logic                       flag_clr,
    output logic                       m_valid,
    output logic [NUM_CH*2*OUT_W-1:0]  m_data,
    output logic                       m_sop,
    output logic                       m_eop,
    output logic                       sat_flag,
    output logic                       len_err
);

    localparam int LANES = NUM_CH * 2;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int PIPE  = 5;  // stages ahead of the output register

    // Chirp state and latched configuration
    logic [IDX_W-1:0]   idx_q, len_q;
    logic [ADDR_W-1:0]  base_q;
    logic               sym_q;
    logic [SHIFT_W-1:0] shift_q;
    logic               seen_sop_q, in_chirp_q;

    // Effective per-sample values
    logic               take_sop;
    logic [IDX_W-1:0]   len_e, idx_cur, off;
    logic [ADDR_W-1:0]  base_e, raddr_d;
    logic               sym_e, oob, len_evt;
    logic [SHIFT_W-1:0] shift_e;

    // Pipeline
    logic [PIPE-1:0]              v_q, sop_q, eop_q;
    logic [NUM_CH*2*DATA_W-1:0]   data0_q, data1_q;
    logic                         oob0_q, oob1_q;
    logic [SHIFT_W-1:0]           sh0_q, sh1_q;
    logic [ADDR_W-1:0]            raddr_q;
    logic [COEF_W-1:0]            coef_mem [DEPTH];
    logic [COEF_W-1:0]            rd_q, coef_s1;
    logic [NUM_CH*2*OUT_W-1:0]    res_w;
    logic [LANES-1:0]             sat_w;

    // Outputs
    logic                         m_valid_q, m_sop_q, m_eop_q, sat_flag_q, len_err_q;
    logic [NUM_CH*2*OUT_W-1:0]    m_data_q;

    // Resolve the config for this sample, its index, RAM address and length violations
    always_comb begin
        // NOTE: every variable here is assigned on every path so no latch is inferred
        take_sop = s_valid & s_sop;
        len_e    = take_sop ? cfg_len   : len_q;
        base_e   = take_sop ? cfg_base  : base_q;
        sym_e    = take_sop ? cfg_sym   : sym_q;
        shift_e  = take_sop ? cfg_shift : shift_q;

        if (take_sop)   idx_cur = '0;
        else if (&idx_q) idx_cur = idx_q;
        else            idx_cur = idx_q + IDX_W'(1);

        oob     = (idx_cur >= len_e);
        off     = sym_e ? sym_offset(idx_cur, len_e) : idx_cur;
        raddr_d = base_e + ADDR_W'(off);

        len_evt = s_valid & (oob
                           | (s_eop & (idx_cur != len_e - IDX_W'(1)))
                           | (s_sop & in_chirp_q)
                           | (~s_sop & ~seen_sop_q));
    end

    // Chirp tracking, config latch and the length-error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            len_q      <= '0;
            base_q     <= '0;
            sym_q      <= 1'b0;
            shift_q    <= '0;
            seen_sop_q <= 1'b0;
            in_chirp_q <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            if (s_valid) begin
                idx_q <= idx_cur;
                if (s_sop) begin
                    len_q      <= cfg_len;
                    base_q     <= cfg_base;
                    sym_q      <= cfg_sym;
                    shift_q    <= cfg_shift;
                    seen_sop_q <= 1'b1;
                end
                if (s_eop)      in_chirp_q <= 1'b0;
                else if (s_sop) in_chirp_q <= 1'b1;
            end
            len_err_q <= (len_err_q & ~flag_clr) | len_evt;
        end
    end

    // Control/data pipeline up to the point where the coefficient is available
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q     <= '0;
            sop_q   <= '0;
            eop_q   <= '0;
            data0_q <= '0;
            data1_q <= '0;
            oob0_q  <= 1'b0;
            oob1_q  <= 1'b0;
            sh0_q   <= '0;
            sh1_q   <= '0;
            raddr_q <= '0;
        end else begin
            v_q     <= {v_q[PIPE-2:0], s_valid};
            sop_q   <= {sop_q[PIPE-2:0], s_valid & s_sop};
            eop_q   <= {eop_q[PIPE-2:0], s_valid & s_eop};
            data0_q <= s_data;
            data1_q <= data0_q;
            oob0_q  <= oob;
            oob1_q  <= oob0_q;
            sh0_q   <= shift_e;
            sh1_q   <= sh0_q;
            raddr_q <= raddr_d;
        end
    end

    // Coefficient RAM: registered address above plus registered read data here
    // NOTE: the array and its read register have no reset; contents persist across rst_n
    always_ff @(posedge clk) begin
        if (coef_we) coef_mem[coef_waddr] <= coef_wdata;
        rd_q <= coef_mem[raddr_q];
    end

    assign coef_s1 = oob1_q ? '0 : rd_q;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        win_r_scale #(
            .DATA_W (DATA_W),
            .COEF_W (COEF_W),
            .OUT_W  (OUT_W)
        ) u_scale (
            .clk     (clk),
            .rst_n   (rst_n),
            .data_i  (data1_q[l*DATA_W +: DATA_W]),
            .coef_i  (coef_s1),
            .shift_i (sh1_q),
            .res_o   (res_w[l*OUT_W +: OUT_W]),
            .sat_o   (sat_w[l])
        );
    end

    // Output register and sticky saturation flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q  <= 1'b0;
            m_sop_q    <= 1'b0;
            m_eop_q    <= 1'b0;
            m_data_q   <= '0;
            sat_flag_q <= 1'b0;
        end else begin
            m_valid_q  <= v_q[PIPE-1];
            m_sop_q    <= sop_q[PIPE-1];
            m_eop_q    <= eop_q[PIPE-1];
            m_data_q   <= res_w;
            sat_flag_q <= (sat_flag_q & ~flag_clr) | (v_q[PIPE-1] & (|sat_w));
        end
    end

    assign m_valid  = m_valid_q;
    assign m_sop    = m_sop_q;
    assign m_eop    = m_eop_q;
    assign m_data   = m_data_q;
    assign sat_flag = sat_flag_q;
    assign len_err  = len_err_q;

endmodule

// File: tb/tb_win_r_mc.sv
// Scoreboard bench for win_r_mc: stimulus pushes expected outputs, a monitor pops them.
module tb_win_r_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid, s_sop, s_eop;
    logic [63:0] s_data;
    logic [15:0] cfg_len;
    logic [12:0] cfg_base;
    logic        cfg_sym;
    logic [4:0]  cfg_shift;
    logic        coef_we;
    logic [12:0] coef_waddr;
    logic [15:0] coef_wdata;
    logic        flag_clr;
    logic        m_valid, m_sop, m_eop, sat_flag, len_err;
    logic [63:0] m_data;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    win_r_mc dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_data(s_data), .s_sop(s_sop), .s_eop(s_eop),
        .cfg_len(cfg_len), .cfg_base(cfg_base), .cfg_sym(cfg_sym), .cfg_shift(cfg_shift),
        .coef_we(coef_we), .coef_waddr(coef_waddr), .coef_wdata(coef_wdata),
        .flag_clr(flag_clr),
        .m_valid(m_valid), .m_data(m_data), .m_sop(m_sop), .m_eop(m_eop),
        .sat_flag(sat_flag), .len_err(len_err)
    );

    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        int          t;
    } exp_t;

    exp_t sb[$];
    int errs = 0;
    int checks = 0;

    // Reference model state
    logic [15:0] ram_m [8192];
    int m_idx, m_len, m_base, m_shift;
    bit m_sym, m_seen, m_in_chirp, m_lerr, m_sat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Windowed component from the arithmetic definition
    function automatic logic [15:0] ref_comp(input logic [15:0] d, input logic [15:0] c,
                                             input int sh, output bit sat);
        longint p;
        int s;
        s = (sh > 17) ? 17 : sh;
        p = longint'($signed(d)) * longint'(c);
        if (s > 0) p = p + (longint'(1) <<< (s - 1));
        p = p >>> s;
        sat = (p > 32767) || (p < -32768);
        if (p > 32767) p = 32767;
        else if (p < -32768) p = -32768;
        return p[15:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_idx = 0; m_len = 0; m_base = 0; m_shift = 0;
        m_sym = 0; m_seen = 0; m_in_chirp = 0; m_lerr = 0; m_sat = 0;
    endtask

    // Drive one slot; for a valid sample compute and enqueue the expected output
    task automatic issue(input bit v, input bit sop, input bit eop, input logic [63:0] d);
        logic [63:0] q;
        logic [15:0] c;
        bit oob, s;
        int pos;
        s_valid = v; s_sop = sop; s_eop = eop; s_data = d;
        if (v) begin
            if (sop) begin
                if (m_in_chirp) m_lerr = 1;
                m_len = int'(cfg_len); m_base = int'(cfg_base);
                m_sym = cfg_sym; m_shift = int'(cfg_shift);
                m_idx = 0; m_seen = 1;
            end else begin
                if (!m_seen) m_lerr = 1;
                if (m_idx < 65535) m_idx++;
            end
            oob = (m_idx >= m_len);
            c = 16'h0;
            if (!oob) begin
                pos = (m_sym && m_idx >= (m_len + 1) / 2) ? m_len - 1 - m_idx : m_idx;
                c = ram_m[(m_base + pos) % 8192];
            end
            if (oob) m_lerr = 1;
            if (eop && m_idx != m_len - 1) m_lerr = 1;
            if (eop) m_in_chirp = 0;
            else if (sop) m_in_chirp = 1;
            for (int j = 0; j < 4; j++) begin
                q[16*j +: 16] = ref_comp(d[16*j +: 16], c, m_shift, s);
                if (s) m_sat = 1;
            end
            sb.push_back('{data: q, sop: sop, eop: eop, t: cyc + 6});
        end
        step();
        s_valid = 0; s_sop = 0; s_eop = 0;
    endtask

    task automatic wr(input int a, input logic [15:0] v);
        coef_we = 1; coef_waddr = 13'(a); coef_wdata = v;
        ram_m[a] = v;
        step();
        coef_we = 0;
    endtask

    // gap: 0 none, 1 alternate, 2 random
    task automatic chirp(input int n, input int gap, input bit rnd, input logic [63:0] dfix,
                         input bit with_eop);
        logic [63:0] d;
        for (int k = 0; k < n; k++) begin
            d = rnd ? {$urandom, $urandom} : dfix;
            issue(1, k == 0, with_eop && (k == n - 1), d);
            if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0)) issue(0, 0, 0, d);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && sb.size() > 0; i++) step();
        check({name, "_drain"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic check_flags(input string name);
        check({name, "_sat_flag"}, {63'd0, sat_flag}, {63'd0, m_sat});
        check({name, "_len_err"}, {63'd0, len_err}, {63'd0, m_lerr});
    endtask

    task automatic clear_flags();
        flag_clr = 1;
        step();
        flag_clr = 0;
        m_sat = 0; m_lerr = 0;
        check("flag_clr_sat", {63'd0, sat_flag}, 64'd0);
        check("flag_clr_len", {63'd0, len_err}, 64'd0);
    endtask

    task automatic set_cfg(input int len, input int base, input bit sym, input int sh);
        cfg_len = 16'(len); cfg_base = 13'(base); cfg_sym = sym; cfg_shift = 5'(sh);
    endtask

    // Monitor: pop and compare whenever the DUT presents a sample
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && m_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_output", {63'd0, m_valid}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("m_data", m_data, e.data);
                check("m_sop", {63'd0, m_sop}, {63'd0, e.sop});
                check("m_eop", {63'd0, m_eop}, {63'd0, e.eop});
                check("latency", 64'(cyc), 64'(e.t));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; s_valid = 0; s_sop = 0; s_eop = 0; s_data = '0;
        coef_we = 0; coef_waddr = '0; coef_wdata = '0; flag_clr = 0;
        set_cfg(8, 0, 0, 16);
        model_reset();
        step(); step(); step();
        check("rst_m_valid", {63'd0, m_valid}, 64'd0);
        check("rst_m_data", m_data, 64'd0);
        check("rst_m_sop", {63'd0, m_sop}, 64'd0);
        check("rst_m_eop", {63'd0, m_eop}, 64'd0);
        check("rst_sat_flag", {63'd0, sat_flag}, 64'd0);
        check("rst_len_err", {63'd0, len_err}, 64'd0);
        rst_n = 1;
        step();

        for (int a = 0; a < 8192; a++) wr(a, 16'($urandom));

        // Linear addressing
        for (int a = 0; a < 8; a++) wr(a, 16'h8000);
        set_cfg(8, 0, 0, 16);
        chirp(8, 0, 0, {16'hFC18, 16'd1000, 16'hFC18, 16'd1000}, 1);
        drain("linear");
        check_flags("linear");

        // Symmetric addressing, even and odd lengths
        for (int a = 0; a < 4; a++) wr(100 + a, 16'((a + 1) << 12));
        set_cfg(8, 100, 1, 16);
        chirp(8, 0, 0, {16'h0, 16'h4000, 16'h0, 16'h4000}, 1);
        drain("sym8");
        set_cfg(7, 100, 1, 16);
        chirp(7, 0, 0, {16'h0, 16'h4000, 16'h0, 16'h4000}, 1);
        drain("sym7");
        check_flags("sym");

        // Saturation on a one-sample chirp, then clear
        wr(200, 16'hFFFF);
        set_cfg(1, 200, 0, 0);
        issue(1, 1, 1, {16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF});
        drain("sat");
        check_flags("sat");
        clear_flags();

        // Gapped input, alternating valid
        set_cfg(16, 3000, 0, 16);
        chirp(16, 1, 1, '0, 1);
        drain("gap");
        check_flags("gap");
        clear_flags();

        // Overlong chirp, then sop without a prior eop
        set_cfg(4, 0, 0, 16);
        chirp(6, 0, 1, '0, 1);
        drain("overlong");
        check_flags("overlong");
        clear_flags();
        chirp(3, 0, 1, '0, 0);
        chirp(4, 0, 1, '0, 1);
        drain("no_eop");
        check_flags("no_eop");

        // Reset in the middle of a chirp (len_err is still set going in)
        set_cfg(16, 500, 0, 16);
        chirp(8, 0, 1, '0, 0);
        rst_n = 0;
        #1;
        check("midrst_m_valid", {63'd0, m_valid}, 64'd0);
        check("midrst_m_data", m_data, 64'd0);
        check("midrst_m_sop", {63'd0, m_sop}, 64'd0);
        check("midrst_m_eop", {63'd0, m_eop}, 64'd0);
        check("midrst_len_err", {63'd0, len_err}, 64'd0);
        check("midrst_sat_flag", {63'd0, sat_flag}, 64'd0);
        sb.delete();
        model_reset();
        step(); step();
        rst_n = 1;
        for (int i = 0; i < 8; i++) step();
        set_cfg(4, 10, 0, 16);
        chirp(4, 0, 1, '0, 1);
        drain("post_rst");
        check_flags("post_rst");

        // Config changes mid-chirp must not affect the running chirp
        set_cfg(8, 0, 0, 16);
        issue(1, 1, 0, {$urandom, $urandom});
        set_cfg(3, 50, 1, 2);
        for (int k = 1; k < 8; k++) issue(1, 0, k == 7, {$urandom, $urandom});
        drain("cfg_hold");
        check_flags("cfg_hold");

        // Randomized chirps
        for (int r = 0; r < 12; r++) begin
            int len, n;
            len = $urandom_range(1, 24);
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 26) : len;
            set_cfg(len, $urandom_range(0, 8191), 1'($urandom_range(0, 1)), $urandom_range(0, 20));
            chirp(n, 2, 1, '0, 1);
            drain("rand");
            check_flags("rand");
            clear_flags();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
